neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac.sv | 157 +++++++++++++++
 tb/tb_neuron_mac.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Binary-input neuron: serial weighted sum with saturating accumulator and strict threshold fire.
// Define NEURON_MAC_LEARN_EN to add target/learn ports and a one-cycle weight UPDATE state.
module neuron_mac #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned W_W    = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in_vec,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  threshold,
`ifdef NEURON_MAC_LEARN_EN
  input  logic              target,
  input  logic              learn,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W_W-1:0]    wr_data,
  output logic              wr_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_fire,
  output logic [ACC_W-1:0]  out_sum
);

  localparam int unsigned Depth = 2**ADDR_W;
  localparam logic [ADDR_W:0] IdxEnd = (ADDR_W+1)'(N_IN);
  localparam logic [ADDR_W:0] IdxOne = (ADDR_W+1)'(1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAcc    = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;
`ifdef NEURON_MAC_LEARN_EN
  localparam logic [1:0] StUpdate = 2'd3;
`endif

  logic [1:0]       state_q, state_d;
  logic [ADDR_W:0]  idx_q;
  logic [ACC_W-1:0] acc_q;
  logic [Depth-1:0] vec_q;
  logic [ACC_W-1:0] thr_q;
  logic [ACC_W-1:0] sum_q;
  logic             fire_q;
  logic             wr_err_q;
  logic [W_W-1:0]   weight_q [Depth];
`ifdef NEURON_MAC_LEARN_EN
  logic             target_q;
  logic             learn_q;
`endif

  logic             accept;
  logic             wr_ok;
  logic             last;
  logic [W_W-1:0]   cur_w;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_sat;

  assign accept  = in_valid && in_ready;
  assign last    = (idx_q == IdxEnd);
  assign cur_w   = weight_q[idx_q[ADDR_W-1:0]];
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(cur_w);
  assign acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

  // A write loses to a same-cycle input handshake so the computation sees the old weights.
  assign wr_ok = wr_en && (state_q == StIdle) && !in_valid && ({1'b0, wr_addr} < IdxEnd);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StAcc;
      StAcc:  if (last) state_d = StDone;
      StDone: begin
        if (out_ready) begin
`ifdef NEURON_MAC_LEARN_EN
          state_d = learn_q ? StUpdate : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef NEURON_MAC_LEARN_EN
      StUpdate: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      vec_q   <= '0;
      thr_q   <= '0;
      sum_q   <= '0;
      fire_q  <= 1'b0;
`ifdef NEURON_MAC_LEARN_EN
      target_q <= 1'b0;
      learn_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        vec_q <= Depth'(in_vec);
        thr_q <= threshold;
        acc_q <= '0;
        idx_q <= '0;
`ifdef NEURON_MAC_LEARN_EN
        target_q <= target;
        learn_q  <= learn;
`endif
      end else if (state_q == StAcc) begin
        // Extra terminal step registers the result, giving N_IN+1 cycles of latency.
        if (last) begin
          sum_q  <= acc_q;
          fire_q <= (acc_q > thr_q);
        end else begin
          if (vec_q[idx_q[ADDR_W-1:0]]) acc_q <= acc_sat;
          idx_q <= idx_q + IdxOne;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) weight_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en && !wr_ok;
      if (wr_ok) weight_q[wr_addr] <= wr_data;
`ifdef NEURON_MAC_LEARN_EN
      if ((state_q == StUpdate) && (fire_q != target_q)) begin
        for (int i = 0; i < N_IN; i++) begin
          if (vec_q[i]) begin
            if (target_q && (weight_q[i] != '1)) begin
              weight_q[i] <= weight_q[i] + W_W'(1);
            end else if (!target_q && (weight_q[i] != '0)) begin
              weight_q[i] <= weight_q[i] - W_W'(1);
            end
          end
        end
      end
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_fire  = fire_q;
  assign out_sum   = sum_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac: default instance plus a 6-input, 8-bit-accumulator one.
module tb_neuron_mac;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  in_vec    = '0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] threshold = '0;
  logic        target    = 1'b0;
  logic        learn     = 1'b0;
  logic        wr_en     = 1'b0;
  logic [2:0]  wr_addr   = '0;
  logic [7:0]  wr_data   = '0;
  logic        wr_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_fire;
  logic [15:0] out_sum;

  logic [5:0]  s_vec      = '0;
  logic        s_valid    = 1'b0;
  logic        s_ready;
  logic [7:0]  s_thr      = '0;
  logic        s_wr_en    = 1'b0;
  logic [3:0]  s_wr_addr  = '0;
  logic [7:0]  s_wr_data  = '0;
  logic        s_wr_err;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic        s_fire;
  logic [7:0]  s_sum;

  int checks = 0;
  int errors = 0;

  neuron_mac u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .threshold (threshold),
`ifdef NEURON_MAC_LEARN_EN
    .target    (target),
    .learn     (learn),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fire  (out_fire),
    .out_sum   (out_sum)
  );

  neuron_mac #(
    .N_IN   (6),
    .ADDR_W (4),
    .W_W    (8),
    .ACC_W  (8)
  ) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vec    (s_vec),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .threshold (s_thr),
`ifdef NEURON_MAC_LEARN_EN
    .target    (1'b0),
    .learn     (1'b0),
`endif
    .wr_en     (s_wr_en),
    .wr_addr   (s_wr_addr),
    .wr_data   (s_wr_data),
    .wr_err    (s_wr_err),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_fire  (s_fire),
    .out_sum   (s_sum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic start(input logic [7:0] v, input logic [15:0] thr);
    in_vec = v; threshold = thr; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Cycles counted from the accept edge (already consumed by the caller) to out_valid.
  task automatic wait_out(input int exp_lat, input string tag);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic result(input logic [15:0] sum, input logic fire, input string tag);
    check({tag, "_sum"}, 32'(out_sum), 32'(sum));
    check({tag, "_fire"}, 32'(out_fire), 32'(fire));
  endtask

  task automatic release_out(input string tag);
    int n = 0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    while (!in_ready && n < 4) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run(input logic [7:0] v, input logic [15:0] thr, input logic [15:0] sum,
                     input logic fire, input string tag);
    start(v, thr);
    wait_out(9, tag);
    result(sum, fire, tag);
    release_out(tag);
  endtask

  initial begin
    logic [7:0] wts [8] = '{8'hEA, 8'h06, 8'h01, 8'h02, 8'h2A, 8'h1F, 8'h01, 8'h0A};
    int lat;

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_fire", 32'(out_fire), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) wr(3'(i), wts[i]);
    check("wr_ok_no_err", 32'(wr_err), 32'd0);

    run(8'h01, 16'h0080, 16'h00EA, 1'b1, "single");
    // bits 1,2,4,7 -> 6+1+0x2A+0x0A
    run(8'h96, 16'h003B, 16'h003B, 1'b0, "eq_thr");
    run(8'h96, 16'h003A, 16'h003B, 1'b1, "gt_thr");
    // bits 1,2,3,7 -> 6+1+2+0x0A
    run(8'h8E, 16'h0013, 16'h0013, 1'b0, "mix");

    // Full vector sums to 0x147; hold the result for five cycles without out_ready.
    start(8'hFF, 16'h0146);
    wait_out(9, "stall");
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(out_sum), 32'h147);
      check("stall_fire", 32'(out_fire), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    release_out("stall");

    // Write during ACC is rejected and pulses wr_err for exactly one cycle.
    start(8'h01, 16'h0000);
    wr(3'd0, 8'h00);
    check("acc_wr_err", 32'(wr_err), 32'd1);
    wait_out(8, "acc_wr");
    check("acc_wr_err_clr", 32'(wr_err), 32'd0);
    result(16'h00EA, 1'b1, "acc_wr");
    release_out("acc_wr");

    // Write coinciding with an accepted input: input wins, old weights used, write dropped.
    in_vec = 8'h01; threshold = 16'h0000; in_valid = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h11;
    step();
    in_valid = 1'b0; wr_en = 1'b0;
    check("coin_wr_err", 32'(wr_err), 32'd1);
    check("coin_in_ready", 32'(in_ready), 32'd0);
    wait_out(9, "coin");
    result(16'h00EA, 1'b1, "coin");
    release_out("coin");
    run(8'h01, 16'h00EA, 16'h00EA, 1'b0, "coin_kept");

    // A write is visible to a computation accepted on the very next cycle.
    wr(3'd7, 8'h50);
    run(8'h80, 16'h004F, 16'h0050, 1'b1, "next_cyc");

    // Reset mid-ACC takes effect without a clock edge.
    start(8'hFF, 16'h0000);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_out_fire", 32'(out_fire), 32'd0);
    check("midrst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'hFF, 16'h0000, 16'h0000, 1'b0, "w_cleared");

`ifdef NEURON_MAC_LEARN_EN
    target = 1'b1; learn = 1'b1;
    run(8'h03, 16'h0000, 16'h0000, 1'b0, "learn_up");
    learn = 1'b0;
    run(8'hFF, 16'h0000, 16'h0002, 1'b1, "learn_up_chk");
    // w0=1, w2=0: fires, target=0 decrements w0 and leaves w2 saturated at 0.
    target = 1'b0; learn = 1'b1;
    run(8'h05, 16'h0000, 16'h0001, 1'b1, "learn_dn");
    learn = 1'b0;
    run(8'hFF, 16'h0000, 16'h0001, 1'b1, "learn_dn_chk");
`endif

    // Small instance: saturating accumulator and out-of-range writes.
    for (int i = 0; i < 6; i++) begin
      s_wr_en = 1'b1; s_wr_addr = 4'(i); s_wr_data = 8'hFF;
      step();
    end
    s_wr_en = 1'b0;
    check("s_wr_ok", 32'(s_wr_err), 32'd0);
    s_wr_en = 1'b1; s_wr_addr = 4'd8; s_wr_data = 8'h00;
    step();
    check("s_wr_addr8_err", 32'(s_wr_err), 32'd1);
    s_wr_addr = 4'd6;
    step();
    s_wr_en = 1'b0;
    check("s_wr_addr6_err", 32'(s_wr_err), 32'd1);
    step();
    check("s_wr_err_clr", 32'(s_wr_err), 32'd0);

    s_vec = 6'h3F; s_thr = 8'hFE; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("s_sat_valid", 32'(s_out_valid), 32'd1);
    check("s_sat_lat", lat, 32'd7);
    check("s_sat_sum", 32'(s_sum), 32'hFF);
    check("s_sat_fire", 32'(s_fire), 32'd1);
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    check("s_idle", 32'(s_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
